// File: rtl/dmux_hs.sv
// dmux_hs: registered 1-to-N demultiplexer with per-channel valid/ready handshake,
// broadcast mode, accepted-word counter and select-error pulse.
module dmux_hs #(
    parameter int W    = 1,
    parameter int N    = 8,
    parameter int SELW = 3,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    a,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [SELW-1:0] sel,
    input  logic            bcast,
    output logic [N*W-1:0]  dmout,
    output logic [N-1:0]    dmout_valid,
    input  logic [N-1:0]    dmout_ready,
    output logic [CNTW-1:0] cnt,
    output logic            sel_err
);
    logic [N-1:0] free, tgt;
    logic         sel_ok, acc;
    always_comb begin
        free   = ~dmout_valid | dmout_ready;
        sel_ok = {1'b0, sel} < (SELW+1)'(N);
        for (int i = 0; i < N; i++) tgt[i] = bcast | (sel == SELW'(i));
        // out-of-range select is swallowed, so it never stalls the producer
        a_ready = bcast ? &free : (sel_ok ? |(tgt & free) : 1'b1);
        acc     = a_valid & a_ready;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dmout       <= '0;
            dmout_valid <= '0;
            cnt         <= '0;
            sel_err     <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++)
                if (acc & tgt[i]) begin
                    dmout[i*W +: W] <= a;
                    dmout_valid[i]  <= 1'b1;
                end else if (dmout_ready[i])
                    dmout_valid[i] <= 1'b0;
            cnt     <= cnt + CNTW'(acc & (bcast | sel_ok));
            sel_err <= acc & ~bcast & ~sel_ok;
        end
endmodule

// File: tb/tb_dmux_hs.sv
// tb_dmux_hs: self-checking bench for dmux_hs with an 8-channel and a 6-channel instance
// compared every cycle against a behavioural channel-occupancy model.
module tb_dmux_hs;
    logic clk = 0, rst = 0;
    always #5 clk = ~clk;

    logic [1:0][3:0] a;
    logic [1:0][2:0] sel;
    logic [1:0]      a_valid, bcast;
    logic [1:0][7:0] rdy;
    logic [31:0]     dm0;
    logic [23:0]     dm1;
    logic [7:0]      dv0;
    logic [5:0]      dv1;
    logic            ar0, ar1, se0, se1;
    logic [3:0]      cnt0, cnt1;

    int n_cmp = 0, n_bad = 0;
    string tname = "";

    logic [3:0] md [2][8];
    bit         mv [2][8];
    int         mcnt [2];
    bit         mse [2];

    dmux_hs #(.W(4), .N(8), .SELW(3), .CNTW(4)) u0 (
        .clk(clk), .rst(rst), .a(a[0]), .a_valid(a_valid[0]), .a_ready(ar0),
        .sel(sel[0]), .bcast(bcast[0]), .dmout(dm0), .dmout_valid(dv0),
        .dmout_ready(rdy[0]), .cnt(cnt0), .sel_err(se0));

    dmux_hs #(.W(4), .N(6), .SELW(3), .CNTW(4)) u1 (
        .clk(clk), .rst(rst), .a(a[1]), .a_valid(a_valid[1]), .a_ready(ar1),
        .sel(sel[1]), .bcast(bcast[1]), .dmout(dm1), .dmout_valid(dv1),
        .dmout_ready(rdy[1][5:0]), .cnt(cnt1), .sel_err(se1));

    function automatic bit exp_ready(int k);
        int n = k ? 6 : 8;
        if (bcast[k]) begin
            for (int i = 0; i < n; i++) if (mv[k][i] && !rdy[k][i]) return 0;
            return 1;
        end
        if (int'(sel[k]) >= n) return 1;
        return !mv[k][sel[k]] || rdy[k][sel[k]];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                mv[k][i] = 0;
                md[k][i] = 0;
            end
            mcnt[k] = 0;
            mse[k]  = 0;
        end
    endtask

    // drive one cycle on instance d, check both instances against the model before the edge
    task automatic drive_cycle(int d, bit va, logic [3:0] av, logic [2:0] s, bit bc, logic [7:0] r);
        bit er [2];
        logic [31:0] gdm, edm, dmask;
        logic [7:0]  gdv, edv;
        logic [3:0]  gc;
        logic        gr, gse;
        a_valid[d] = va;
        a[d]       = av;
        sel[d]     = s;
        bcast[d]   = bc;
        rdy[d]     = r;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int n = k ? 6 : 8;
            er[k] = exp_ready(k);
            gr  = k ? ar1 : ar0;
            gdm = k ? {8'h0, dm1} : dm0;
            gdv = k ? {2'b0, dv1} : dv0;
            gc  = k ? cnt1 : cnt0;
            gse = k ? se1 : se0;
            edv = '0; edm = '0; dmask = '0;
            for (int i = 0; i < n; i++) if (mv[k][i]) begin
                edv[i] = 1'b1;
                edm[i*4 +: 4] = md[k][i];
                dmask[i*4 +: 4] = 4'hF;
            end
            n_cmp += 5;
            if (gr !== er[k]) begin
                n_bad++;
                $display("FAIL %s dut%0d a_ready: got %b want %b", tname, k, gr, er[k]);
            end
            if (gdv !== edv) begin
                n_bad++;
                $display("FAIL %s dut%0d dmout_valid: got %b want %b", tname, k, gdv, edv);
            end
            if ((gdm & dmask) !== edm) begin
                n_bad++;
                $display("FAIL %s dut%0d dmout: got %h want %h", tname, k, gdm & dmask, edm);
            end
            if (gc !== 4'(mcnt[k])) begin
                n_bad++;
                $display("FAIL %s dut%0d cnt: got %0d want %0d", tname, k, gc, mcnt[k]);
            end
            if (gse !== mse[k]) begin
                n_bad++;
                $display("FAIL %s dut%0d sel_err: got %b want %b", tname, k, gse, mse[k]);
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            int n = k ? 6 : 8;
            bit acc = a_valid[k] && er[k];
            for (int i = 0; i < n; i++)
                if (acc && (bcast[k] || int'(sel[k]) == i)) begin
                    md[k][i] = a[k];
                    mv[k][i] = 1;
                end else if (rdy[k][i])
                    mv[k][i] = 0;
            mcnt[k] = (mcnt[k] + ((acc && (bcast[k] || int'(sel[k]) < n)) ? 1 : 0)) % 16;
            mse[k]  = acc && !bcast[k] && int'(sel[k]) >= n;
        end
    endtask

    task automatic idle(int d);
        drive_cycle(d, 0, 4'h0, 3'd0, 0, 8'hFF);
    endtask

    task automatic test_reset();
        tname = "reset";
        #11;
        n_cmp += 4;
        if ({dv0, dv1} !== 14'h0) begin
            n_bad++;
            $display("FAIL reset valid: got %b/%b want 0", dv0, dv1);
        end
        if ({dm0, dm1} !== 56'h0) begin
            n_bad++;
            $display("FAIL reset dmout: got %h/%h want 0", dm0, dm1);
        end
        if ({cnt0, cnt1, se0, se1} !== 10'h0) begin
            n_bad++;
            $display("FAIL reset cnt/sel_err: got %h %h %b %b want 0", cnt0, cnt1, se0, se1);
        end
        if ({ar0, ar1} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset a_ready: got %b%b want 11", ar0, ar1);
        end
        rst = 0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        tname = "stream";
        for (int i = 0; i < 8; i++) drive_cycle(0, 1, 4'(i + 1), 3'(i), 0, 8'hFF);
        n_cmp += 2;
        if (cnt0 !== 4'd8) begin
            n_bad++;
            $display("FAIL stream cnt: got %0d want 8", cnt0);
        end
        if (dv0 !== 8'h80 || dm0[31:28] !== 4'h8) begin
            n_bad++;
            $display("FAIL stream last: got valid %b data %h want 10000000 8", dv0, dm0[31:28]);
        end
        idle(0);
        idle(0);
    endtask

    task automatic test_backpressure();
        tname = "backpressure";
        drive_cycle(0, 1, 4'hA, 3'd3, 0, 8'hF7);
        drive_cycle(0, 1, 4'hB, 3'd3, 0, 8'hF7);
        drive_cycle(0, 1, 4'hB, 3'd3, 0, 8'hF7);
        n_cmp++;
        if (dv0[3] !== 1'b1 || dm0[15:12] !== 4'hA) begin
            n_bad++;
            $display("FAIL backpressure hold: got valid %b data %h want 1 a", dv0[3], dm0[15:12]);
        end
        drive_cycle(0, 1, 4'hB, 3'd3, 0, 8'hFF);
        n_cmp++;
        if (dv0[3] !== 1'b1 || dm0[15:12] !== 4'hB) begin
            n_bad++;
            $display("FAIL backpressure reload: got valid %b data %h want 1 b", dv0[3], dm0[15:12]);
        end
        idle(0);
        idle(0);
    endtask

    task automatic test_broadcast();
        tname = "broadcast";
        drive_cycle(0, 1, 4'hC, 3'd6, 0, 8'hBF);
        drive_cycle(0, 1, 4'h5, 3'd2, 1, 8'hBF);
        drive_cycle(0, 1, 4'h5, 3'd2, 1, 8'hBF);
        n_cmp++;
        if (dv0 !== 8'h40 || dm0[27:24] !== 4'hC) begin
            n_bad++;
            $display("FAIL broadcast stall: got valid %b data %h want 01000000 c", dv0, dm0[27:24]);
        end
        drive_cycle(0, 1, 4'h5, 3'd2, 1, 8'hFF);
        n_cmp++;
        if (dv0 !== 8'hFF || dm0 !== 32'h55555555) begin
            n_bad++;
            $display("FAIL broadcast all: got valid %b data %h want ff 55555555", dv0, dm0);
        end
        idle(0);
        n_cmp++;
        if (dv0 !== 8'h00) begin
            n_bad++;
            $display("FAIL broadcast pulse: got valid %b want 0", dv0);
        end
    endtask

    task automatic test_sel_err();
        tname = "sel_err";
        drive_cycle(1, 1, 4'h2, 3'd7, 0, 8'h3F);
        n_cmp++;
        if (se1 !== 1'b1 || dv1 !== 6'h0) begin
            n_bad++;
            $display("FAIL sel_err drop: got sel_err %b valid %b want 1 0", se1, dv1);
        end
        drive_cycle(1, 1, 4'h3, 3'd6, 0, 8'h3F);
        idle(1);
        n_cmp++;
        if (se1 !== 1'b0) begin
            n_bad++;
            $display("FAIL sel_err pulse: got %b want 0", se1);
        end
        idle(1);
    endtask

    task automatic test_cnt_wrap();
        logic [3:0] prev;
        bit saw_wrap = 0;
        tname = "cnt_wrap";
        for (int i = 0; i < 17; i++) begin
            prev = cnt0;
            drive_cycle(0, 1, 4'($urandom), 3'($urandom), 0, 8'hFF);
            if (prev == 4'd15 && cnt0 == 4'd0) saw_wrap = 1;
        end
        n_cmp++;
        if (saw_wrap !== 1'b1) begin
            n_bad++;
            $display("FAIL cnt_wrap: got no 15->0 step want wrap, cnt now %0d", cnt0);
        end
        idle(0);
    endtask

    task automatic test_random();
        tname = "random";
        for (int i = 0; i < 400; i++)
            drive_cycle(int'($urandom_range(0, 1)), ($urandom % 4) != 0, 4'($urandom),
                        3'($urandom), ($urandom % 8) == 0, 8'($urandom | $urandom));
        idle(0);
        idle(1);
    endtask

    task automatic test_async_reset();
        tname = "async_reset";
        drive_cycle(0, 1, 4'h9, 3'd2, 0, 8'hDB);
        drive_cycle(0, 1, 4'h6, 3'd5, 0, 8'hDB);
        drive_cycle(1, 1, 4'h3, 3'd2, 0, 8'h1B);
        drive_cycle(1, 1, 4'h4, 3'd5, 0, 8'h1B);
        drive_cycle(0, 1, 4'h7, 3'd2, 0, 8'hDB);
        #2 rst = 1;
        #1;
        n_cmp += 3;
        if ({dv0, dv1} !== 14'h0 || {dm0, dm1} !== 56'h0) begin
            n_bad++;
            $display("FAIL async_reset data: got %b/%b %h/%h want 0", dv0, dv1, dm0, dm1);
        end
        if ({cnt0, cnt1, se0, se1} !== 10'h0) begin
            n_bad++;
            $display("FAIL async_reset cnt: got %h %h %b %b want 0", cnt0, cnt1, se0, se1);
        end
        if (ar0 !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset a_ready: got %b want 1", ar0);
        end
        a_valid = 2'b00;
        model_clear();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 60; i++)
            drive_cycle(int'($urandom_range(0, 1)), ($urandom % 3) != 0, 4'($urandom),
                        3'($urandom), ($urandom % 10) == 0, 8'($urandom | $urandom));
    endtask

    initial begin
        a = '0; sel = '0; a_valid = '0; bcast = '0; rdy = '1;
        #1 rst = 1;
        test_reset();
        test_stream();
        test_backpressure();
        test_broadcast();
        test_sel_err();
        test_cnt_wrap();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
